muldiv_unit: RTL and testbench

Parametrised iterative multiply/divide unit for the EX stage, handling MULT, MULTU, DIV and DIVU behind one start/ready handshake. It is the single HI/LO-producing arithmetic engine. EX stalls the pipeline while `busy_o` is high and writes `result_o` into HI/LO on `ready_o`. It is radix-2: one multiply or divide step per clock. It adds divide-by-zero signalling, annul, and an optional fast multiply path.

---
 rtl/muldiv_unit.sv | 219 +++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Radix-2 iterative MULT/MULTU/DIV/DIVU engine producing {HI, LO} behind a start/ready handshake.
// Define MULDIV_FAST_MUL_EN to replace the shift-add multiplier with a single-cycle registered product.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [1:0]         op_i,
  input  logic [WIDTH-1:0]   opa_i,
  input  logic [WIDTH-1:0]   opb_i,
  input  logic               annul_i,
  output logic               busy_o,
  output logic               ready_o,
  output logic [2*WIDTH-1:0] result_o,
  output logic               div_zero_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_DONE = 3'd3
`ifdef MULDIV_FAST_MUL_EN
    , S_FMUL = 3'd4
`endif
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic               sa_q, sa_d, sb_q, sb_d;
  logic [WIDTH-1:0]   a_q, a_d;       // |multiplicand| or |divisor|
  logic [WIDTH-1:0]   hi_q, hi_d;     // product high half or partial remainder
  logic [WIDTH-1:0]   lo_q, lo_d;     // multiplier/product low half or dividend/quotient
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               dz_q, dz_d;

  logic               signed_in;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic               last_step;
  logic               neg_res, neg_rem;
  logic [WIDTH:0]     div_trial, div_diff;
  logic               div_qbit;
  logic [WIDTH-1:0]   div_rem, div_quo;
  logic [2*WIDTH-1:0] mul_prod;
  logic [2*WIDTH-1:0] result_fixed;

  assign signed_in = ~op_i[0];
  assign abs_a     = (signed_in && opa_i[WIDTH-1]) ? -opa_i : opa_i;
  assign abs_b     = (signed_in && opb_i[WIDTH-1]) ? -opb_i : opb_i;
  assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

  // Restoring step: the W+1-bit difference sign says whether the divisor fits.
  assign div_trial = {hi_q, lo_q[WIDTH-1]};
  assign div_diff  = div_trial - {1'b0, a_q};
  assign div_qbit  = ~div_diff[WIDTH];
  assign div_rem   = div_qbit ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0];
  assign div_quo   = {lo_q[WIDTH-2:0], div_qbit};

`ifdef MULDIV_FAST_MUL_EN
  assign mul_prod = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, lo_q};
`else
  logic [WIDTH:0] mul_sum;
  assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
  assign mul_prod = {mul_sum, lo_q[WIDTH-1:1]};
`endif

  assign neg_res = ~op_q[0] & (sa_q ^ sb_q);
  assign neg_rem = ~op_q[0] & sa_q;
  assign result_fixed = op_q[1]
    ? {(neg_rem ? -div_rem : div_rem), (neg_res ? -div_quo : div_quo)}
    : (neg_res ? -mul_prod : mul_prod);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_i && !annul_i) begin
          if (op_i[1]) begin
            state_d = (opb_i == '0) ? S_DONE : S_DIV;
          end else begin
`ifdef MULDIV_FAST_MUL_EN
            state_d = S_FMUL;
`else
            state_d = S_MUL;
`endif
          end
        end
      end
`ifdef MULDIV_FAST_MUL_EN
      S_FMUL:  state_d = annul_i ? S_IDLE : S_DONE;
`else
      S_MUL:   state_d = annul_i ? S_IDLE : (last_step ? S_DONE : S_MUL);
`endif
      S_DIV:   state_d = annul_i ? S_IDLE : (last_step ? S_DONE : S_DIV);
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o     = 1'b0;
    ready_o    = 1'b0;
    result_o   = result_q;
    div_zero_o = dz_q;
    case (state_q)
`ifdef MULDIV_FAST_MUL_EN
      S_FMUL:  busy_o = 1'b1;
`else
      S_MUL:   busy_o = 1'b1;
`endif
      S_DIV:   busy_o = 1'b1;
      S_DONE:  ready_o = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    op_d     = op_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    a_d      = a_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    dz_d     = dz_q;
    case (state_q)
      S_IDLE: begin
        if (start_i && !annul_i) begin
          op_d  = op_i;
          sa_d  = opa_i[WIDTH-1];
          sb_d  = opb_i[WIDTH-1];
          cnt_d = '0;
          hi_d  = '0;
          if (op_i[1]) begin
            lo_d = abs_a;
            a_d  = abs_b;
            if (opb_i == '0) begin
              result_d = {opa_i, {WIDTH{1'b1}}};
              dz_d     = 1'b1;
            end
          end else begin
            lo_d = abs_b;
            a_d  = abs_a;
          end
        end
      end
`ifdef MULDIV_FAST_MUL_EN
      S_FMUL: begin
        if (!annul_i) begin
          result_d = result_fixed;
          dz_d     = 1'b0;
        end
      end
`else
      S_MUL: begin
        if (!annul_i) begin
          hi_d  = mul_sum[WIDTH:1];
          lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
          cnt_d = cnt_q + CNT_W'(1);
          if (last_step) begin
            result_d = result_fixed;
            dz_d     = 1'b0;
          end
        end
      end
`endif
      S_DIV: begin
        if (!annul_i) begin
          hi_d  = div_rem;
          lo_d  = div_quo;
          cnt_d = cnt_q + CNT_W'(1);
          if (last_step) begin
            result_d = result_fixed;
            dz_d     = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      a_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      dz_q     <= 1'b0;
    end else begin
      op_q     <= op_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      a_q      <= a_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      dz_q     <= dz_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (WIDTH = 32): latency, busy window, results, div-by-zero, annul and reset.
module tb_muldiv_unit;
  localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int ML = 2;
  localparam logic [1:0] ANNUL_OP = 2'b11;
`else
  localparam int ML = W + 1;
  localparam logic [1:0] ANNUL_OP = 2'b01;
`endif
  localparam int DL = W + 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           start_i;
  logic [1:0]     op_i;
  logic [W-1:0]   opa_i;
  logic [W-1:0]   opb_i;
  logic           annul_i;
  logic           busy_o;
  logic           ready_o;
  logic [2*W-1:0] result_o;
  logic           div_zero_o;

  int n_cmp = 0;
  int n_bad = 0;
  int nbusy;
  int nready;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .op_i       (op_i),
    .opa_i      (opa_i),
    .opb_i      (opb_i),
    .annul_i    (annul_i),
    .busy_o     (busy_o),
    .ready_o    (ready_o),
    .result_o   (result_o),
    .div_zero_o (div_zero_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Launches one op and checks latency, busy window, result, flag and the single-cycle ready pulse.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int exp_lat, input logic [63:0] exp_res,
                        input logic exp_dz);
    int lat;
    int busy_cnt;
    op_i = op; opa_i = a; opb_i = b; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    lat = 0;
    busy_cnt = 0;
    for (int c = 1; c <= 100; c++) begin
      if (ready_o) begin
        lat = c;
        break;
      end
      if (busy_o) busy_cnt++;
      tick();
    end
    $display("op %s: op=%b a=%h b=%h -> lat=%0d result=%h dz=%b", tag, op, a, b, lat, result_o, div_zero_o);
    check({tag, "/latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "/busy_cycles"}, 64'(busy_cnt), 64'(exp_lat - 1));
    check({tag, "/busy_at_ready"}, 64'(busy_o), 64'd0);
    check({tag, "/result"}, result_o, exp_res);
    check({tag, "/div_zero"}, 64'(div_zero_o), 64'(exp_dz));
    tick();
    check({tag, "/ready_pulse"}, 64'(ready_o), 64'd0);
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; op_i = 2'b00; opa_i = '0; opb_i = '0;
    tick();
    tick();
    check("reset/result", result_o, 64'd0);
    check("reset/busy", 64'(busy_o), 64'd0);
    check("reset/ready", 64'(ready_o), 64'd0);
    check("reset/div_zero", 64'(div_zero_o), 64'd0);
    rst = 1'b0;
    tick();

    run_op("mult_neg1x7", 2'b00, 32'hFFFF_FFFF, 32'h0000_0007, ML, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0);
    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ML, 64'hFFFF_FFFE_0000_0001, 1'b0);
    run_op("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002, DL, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
    run_op("divu_7_2", 2'b11, 32'h0000_0007, 32'h0000_0002, DL, 64'h0000_0001_0000_0003, 1'b0);
    run_op("div_min_m1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, DL, 64'h0000_0000_8000_0000, 1'b0);
    run_op("divu_by0", 2'b11, 32'h1234_5678, 32'h0000_0000, 1, 64'h1234_5678_FFFF_FFFF, 1'b1);
    check("divu_by0/flag_holds", 64'(div_zero_o), 64'd1);
    run_op("divu_9_3", 2'b11, 32'h0000_0009, 32'h0000_0003, DL, 64'h0000_0000_0000_0003, 1'b0);
    run_op("mult_minxmin", 2'b00, 32'h8000_0000, 32'h8000_0000, ML, 64'h4000_0000_0000_0000, 1'b0);

    // Annul in cycle 10, with an ignored start (a divide by zero) pulsed in cycle 5.
    op_i = ANNUL_OP; opa_i = 32'd3; opb_i = 32'd5; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    nbusy = 0;
    nready = 0;
    for (int c = 1; c < 10; c++) begin
      if (busy_o) nbusy++;
      if (ready_o) nready++;
      if (c == 5) begin
        op_i = 2'b11; opa_i = 32'hDEAD_BEEF; opb_i = 32'd0; start_i = 1'b1;
      end
      tick();
      start_i = 1'b0;
    end
    if (busy_o) nbusy++;
    annul_i = 1'b1;
    tick();
    annul_i = 1'b0;
    $display("op annul: busy_cycles=%0d ready_seen=%0d busy=%b result=%h", nbusy, nready, busy_o, result_o);
    check("annul/busy_cycles", 64'(nbusy), 64'd10);
    check("annul/busy_after", 64'(busy_o), 64'd0);
    check("annul/ready_after", 64'(ready_o), 64'd0);
    check("annul/result_held", result_o, 64'h4000_0000_0000_0000);
    for (int c = 0; c < 40; c++) begin
      if (ready_o) nready++;
      tick();
    end
    check("annul/no_ready", 64'(nready), 64'd0);

    // Annul together with start in IDLE launches nothing.
    op_i = 2'b11; opa_i = 32'd1; opb_i = 32'd0; start_i = 1'b1; annul_i = 1'b1;
    tick();
    start_i = 1'b0; annul_i = 1'b0;
    $display("op annul_start: busy=%b ready=%b dz=%b", busy_o, ready_o, div_zero_o);
    check("annul_start/busy", 64'(busy_o), 64'd0);
    check("annul_start/ready", 64'(ready_o), 64'd0);
    check("annul_start/div_zero", 64'(div_zero_o), 64'd0);
    tick();

    run_op("divu_ff_by0", 2'b11, 32'h0000_00FF, 32'h0000_0000, 1, 64'h0000_00FF_FFFF_FFFF, 1'b1);

    // Reset in cycle 15 of a DIV discards it and clears every output.
    op_i = 2'b10; opa_i = 32'd100; opb_i = 32'd7; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int c = 1; c < 15; c++) tick();
    check("rst_mid/busy_before", 64'(busy_o), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    $display("op rst_mid: busy=%b ready=%b dz=%b result=%h", busy_o, ready_o, div_zero_o, result_o);
    check("rst_mid/result", result_o, 64'd0);
    check("rst_mid/busy", 64'(busy_o), 64'd0);
    check("rst_mid/ready", 64'(ready_o), 64'd0);
    check("rst_mid/div_zero", 64'(div_zero_o), 64'd0);

    run_op("div_100_7", 2'b10, 32'd100, 32'd7, DL, 64'h0000_0002_0000_000E, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
